// File: rtl/ring_noc.sv
// Slotted ring network-on-chip: each node owns an injection FIFO and one
// registered slot toward its clockwise neighbour. Flits carry their
// destination node ID in the top NODEW bits and eject at that node.
module ring_noc #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDWIDTH = 5,
  parameter int NODES    = 4,
  parameter int NODEW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NODES-1:0]       write,
  input  logic [NODES*WIDTH-1:0] dataIn,
  output logic [NODES*WIDTH-1:0] dataOut,
  output logic [NODES-1:0]       validOut,
  output logic [NODES-1:0]       full,
  output logic [NODES-1:0]       almost_full
);

  localparam logic [ADDWIDTH:0] CNT_FULL = (ADDWIDTH + 1)'(DEPTH);
  localparam logic [ADDWIDTH:0] CNT_AF   = (ADDWIDTH + 1)'(DEPTH - 1);

  // Ring slots (slot g travels from node g to node g+1) and ejection registers
  logic             slot_v [NODES];
  logic [WIDTH-1:0] slot_d [NODES];
  logic             out_v  [NODES];
  logic [WIDTH-1:0] out_d  [NODES];

  for (genvar g = 0; g < NODES; g++) begin : g_node
    localparam int PREV = (g + NODES - 1) % NODES;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDWIDTH-1:0] rd_ptr;
    logic [ADDWIDTH-1:0] wr_ptr;
    logic [ADDWIDTH:0]   count;
    logic                in_v;
    logic [WIDTH-1:0]    in_d;
    logic                is_full;
    logic                push;
    logic                pop;
    logic                eject;
    logic                fwd;

    // Per-node arbitration: eject beats forward; a consumed or empty
    // incoming slot frees this node's slot for its FIFO head.
    always_comb begin
      in_v    = slot_v[PREV];
      in_d    = slot_d[PREV];
      is_full = (count == CNT_FULL);
      push    = write[g] && !is_full;
      eject   = in_v && (in_d[WIDTH-1 -: NODEW] == NODEW'(g));
      fwd     = in_v && !eject;
      pop     = !fwd && (count != '0);
    end

    assign full[g]                   = is_full;
    assign almost_full[g]            = (count >= CNT_AF);
    assign dataOut[g*WIDTH +: WIDTH] = out_d[g];
    assign validOut[g]               = out_v[g];

    // FIFO storage write port
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dataIn[g*WIDTH +: WIDTH];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end

    // Outgoing slot and local ejection registers
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_v[g] <= 1'b0;
        slot_d[g] <= '0;
        out_v[g]  <= 1'b0;
        out_d[g]  <= '0;
      end else begin
        out_v[g] <= eject;
        if (eject) out_d[g] <= in_d;
        if (fwd) begin
          slot_v[g] <= 1'b1;
          slot_d[g] <= in_d;
        end else if (pop) begin
          slot_v[g] <= 1'b1;
          slot_d[g] <= mem[rd_ptr];
        end else begin
          slot_v[g] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_noc.sv
// Testbench for ring_noc: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_ring_noc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  write;
  logic [63:0] dataIn;
  logic [63:0] dataOut;
  logic [3:0]  validOut;
  logic [3:0]  full;
  logic [3:0]  almost_full;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ring_noc #(.WIDTH(16), .DEPTH(32), .ADDWIDTH(5), .NODES(4), .NODEW(2)) dut (
    .clk(clk), .reset(reset), .write(write), .dataIn(dataIn),
    .dataOut(dataOut), .validOut(validOut), .full(full), .almost_full(almost_full)
  );

  // Reference model: FIFOs as queues, ring as an array of in-flight flits
  typedef logic [15:0] fq_t [$];
  fq_t         mq [4];
  bit          rv [4];
  logic [15:0] rd [4];
  logic [3:0]  mv;
  logic [63:0] md;

  task automatic model_step(input bit r, input logic [3:0] w, input logic [63:0] d);
    bit          nv  [4];
    logic [15:0] nd  [4];
    bit          acc [4];
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        rv[i] = 0;
        rd[i] = '0;
      end
      mv = '0;
      md = '0;
      return;
    end
    for (int i = 0; i < 4; i++) acc[i] = w[i] && (mq[i].size() < 32);
    mv = '0;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (i + 3) % 4;
      nv[i] = 0;
      nd[i] = rd[i];
      if (rv[p] && int'(rd[p][15:14]) == i) begin
        mv[i] = 1'b1;
        md[i*16 +: 16] = rd[p];
      end
      if (rv[p] && int'(rd[p][15:14]) != i) begin
        nv[i] = 1;
        nd[i] = rd[p];
      end else if (mq[i].size() > 0) begin
        nv[i] = 1;
        nd[i] = mq[i].pop_front();
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) mq[i].push_back(d[i*16 +: 16]);
      rv[i] = nv[i];
      rd[i] = nd[i];
    end
  endtask

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == 32);
    return f;
  endfunction

  function automatic logic [3:0] model_af();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() >= 31);
    return f;
  endfunction

  // Advance one clock with the currently driven inputs; outputs sampled 1ns after the edge
  task automatic tick();
    model_step(reset, write, dataIn);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  wr;
    logic [63:0] din;
    logic [3:0]  ev;
    logic [63:0] ed;
  } vec_t;

  vec_t        tbl [20];
  logic [15:0] got [$];
  int          rate;

  initial begin
    reset  = 1'b1;
    write  = '0;
    dataIn = '0;

    // Reset with traffic, unicast 0->2, self-address 1->1, ring priority at node 0
    tbl[0]  = '{1'b1, 4'b1111, 64'h4001_8002_C003_0004, 4'b0000, 64'h0};
    tbl[1]  = '{1'b1, 4'b0101, 64'h0011_8022_4033_C044, 4'b0000, 64'h0};
    tbl[2]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_8ABC, 4'b0000, 64'h0};
    tbl[3]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0};
    tbl[4]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0};
    tbl[5]  = '{1'b0, 4'b0000, 64'h0,                   4'b0100, 64'h0000_8ABC_0000_0000};
    tbl[6]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[7]  = '{1'b0, 4'b0010, 64'h0000_0000_4001_0000, 4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[8]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[9]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[10] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[11] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_0000_0000};
    tbl[12] = '{1'b0, 4'b0000, 64'h0,                   4'b0010, 64'h0000_8ABC_4001_0000};
    tbl[13] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_4001_0000};
    tbl[14] = '{1'b0, 4'b1000, 64'h4033_0000_0000_0000, 4'b0000, 64'h0000_8ABC_4001_0000};
    tbl[15] = '{1'b0, 4'b0001, 64'h0000_0000_0000_4000, 4'b0000, 64'h0000_8ABC_4001_0000};
    tbl[16] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_4001_0000};
    tbl[17] = '{1'b0, 4'b0000, 64'h0,                   4'b0010, 64'h0000_8ABC_4033_0000};
    tbl[18] = '{1'b0, 4'b0000, 64'h0,                   4'b0010, 64'h0000_8ABC_4000_0000};
    tbl[19] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 64'h0000_8ABC_4000_0000};

    for (int k = 0; k < 20; k++) begin
      reset  = tbl[k].rst;
      write  = tbl[k].wr;
      dataIn = tbl[k].din;
      tick();
      check($sformatf("tbl[%0d] validOut", k), 64'(validOut), 64'(tbl[k].ev));
      check($sformatf("tbl[%0d] dataOut", k), dataOut, tbl[k].ed);
      check($sformatf("tbl[%0d] full", k), 64'(full), 64'h0);
      check($sformatf("tbl[%0d] almost_full", k), 64'(almost_full), 64'h0);
    end

    // Full/drop: node 2 streams to node 1, blocking node 3's injection
    reset = 1'b1; write = '0; dataIn = '0;
    tick();
    reset = 1'b0;
    write = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      dataIn[47:32] = 16'h4000 | 16'(s);
      tick();
    end
    for (int k = 0; k < 33; k++) begin
      write = 4'b1100;
      dataIn[47:32] = 16'h4100 | 16'(k);
      dataIn[63:48] = 16'(k + 256);
      tick();
      if (k == 30) begin
        check("af after 31 writes", 64'(almost_full[3]), 64'h1);
        check("full after 31 writes", 64'(full[3]), 64'h0);
      end
      if (k == 31) check("full after 32 writes", 64'(full[3]), 64'h1);
      if (k == 32) check("full after dropped write", 64'(full[3]), 64'h1);
    end
    write = '0; dataIn = '0;
    got.delete();
    for (int c = 0; c < 80; c++) begin
      tick();
      if (validOut[0]) got.push_back(dataOut[15:0]);
    end
    check("drain count", 64'(got.size()), 64'd32);
    for (int j = 0; j < got.size(); j++)
      check($sformatf("drain flit %0d", j), 64'(got[j]), 64'(j + 256));
    check("full after drain", 64'(full), 64'h0);
    check("af after drain", 64'(almost_full), 64'h0);

    // Mid-flight reset: flits in slots and one still queued are discarded
    reset = 1'b1; tick();
    reset = 1'b0;
    write = 4'b0111; dataIn = 64'h0000_4033_0022_8011;
    tick();
    write = 4'b0001; dataIn = 64'h0000_0000_0000_C044;
    tick();
    write = '0; dataIn = '0; reset = 1'b1;
    tick();
    check("reset edge validOut", 64'(validOut), 64'h0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("post-reset %0d validOut", c), 64'(validOut), 64'h0);
      check($sformatf("post-reset %0d dataOut", c), dataOut, 64'h0);
      check($sformatf("post-reset %0d af", c), 64'(almost_full), 64'h0);
    end

    // Randomized traffic against the reference model
    reset = 1'b1; tick();
    rate = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rate = $urandom_range(10, 100);
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        write[i] = ($urandom_range(0, 99) < rate);
        dataIn[i*16 +: 16] = {2'($urandom_range(0, 3)), 14'($urandom)};
      end
      tick();
      check($sformatf("rand %0d validOut", c), 64'(validOut), 64'(mv));
      check($sformatf("rand %0d dataOut", c), dataOut, md);
      check($sformatf("rand %0d full", c), 64'(full), 64'(model_full()));
      check($sformatf("rand %0d almost_full", c), 64'(almost_full), 64'(model_af()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
